// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and sizing helper for the MDU
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } mdu_state_e;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mdu_iter_div.sv
// rtl/mdu_iter_div.sv - div_step_unit: unsigned restoring divider, one quotient bit per run cycle
module div_step_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             run,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             last
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   trial;
  logic             fits;

  // Quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  assign trial = {rem_q, quot_q[WIDTH-1]};
  assign fits  = (trial >= {1'b0, dvs_q});

  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    if (load) begin
      quot_d = a;
      rem_d  = '0;
      dvs_d  = b;
      cnt_d  = '0;
    end else if (run) begin
      quot_d = {quot_q[WIDTH-2:0], fits};
      rem_d  = fits ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign last = run && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(MUL_LAT);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             div_load, div_run, div_last;
  logic             div_signed;
  logic [WIDTH-1:0] a_mag, b_mag, div_quot, div_rem;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic [2*WIDTH-1:0] ext_a, ext_b, product;

  assign div_signed = (op == MDU_DIV);
  assign a_mag = (div_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (div_signed && b[WIDTH-1]) ? -b : b;

  div_step_unit #(.WIDTH(WIDTH)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .load (div_load),
    .a    (a_mag),
    .b    (b_mag),
    .run  (div_run),
    .quot (div_quot),
    .rem  (div_rem),
    .last (div_last)
  );

  // Sign-extending both operands to 2*WIDTH makes one modular multiply serve MULT and MULTU.
  assign ext_a   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign ext_b   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign product = ext_a * ext_b;

  assign quot_fix = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_quot : div_quot;
  assign rem_fix  = (sgn_q && a_q[WIDTH-1]) ? -div_rem : div_rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div_load = 1'b0;
    div_run  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = (op == MDU_MULT);
              cnt_d   = CW'(MUL_LAT - 1);
              busy_d  = 1'b1;
              state_d = ST_MUL;
            end
            MDU_DIV, MDU_DIVU: begin
              a_d      = a;
              b_d      = b;
              sgn_d    = div_signed;
              div_load = 1'b1;
              busy_d   = 1'b1;
              state_d  = ST_DIV;
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = product;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DIV: begin
        div_run = 1'b1;
        if (div_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        // A zero divisor overrides the raw datapath result; MIN/-1 falls out naturally.
        if (b_q == '0) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - self-checking bench for mdu_iter against an arithmetic reference model
module tb_mdu_iter;

  localparam int W  = 32;
  localparam int ML = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           n_assert = 0;
  int           n_fail = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  mdu_iter #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} from plain 64-bit arithmetic; SV / and % already truncate toward zero.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, q, r;
    longint ux, uy;
    logic [63:0] res;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    res = '0;
    case (o)
      3'd0: res = sx * sy;
      3'd1: res = ux * uy;
      3'd2, 3'd3: begin
        if (y == '0) begin
          res = {x, 32'hFFFF_FFFF};
        end else begin
          if (o == 3'd2) begin
            q = sx / sy;
            r = sx % sy;
          end else begin
            q = ux / uy;
            r = ux % uy;
          end
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = {hi_m, lo_m};
    endcase
    return res;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit chk_after, input bit inject);
    logic [63:0] e;
    int n;
    int lat;
    e   = ref_op(o, x, y);
    lat = (o < 3'd2) ? ML : W + 1;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    check("done_after_accept", {63'd0, done}, 64'd0);
    n = 0;
    while (busy && n < 100) begin
      if (inject && n == 2) begin
        start = 1'b1; op = 3'b101; a = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (busy) check("done_while_busy", {63'd0, done}, 64'd0);
    end
    start = 1'b0;
    check("latency", 64'(n), 64'(lat));
    check("done_pulse", {63'd0, done}, 64'd1);
    check("hi_result", {32'd0, hi}, {32'd0, e[63:32]});
    check("lo_result", {32'd0, lo}, {32'd0, e[31:0]});
    hi_m = e[63:32];
    lo_m = e[31:0];
    if (chk_after) begin
      @(posedge clk); #1;
      check("done_one_cycle", {63'd0, done}, 64'd0);
      check("idle_after_done", {63'd0, busy}, 64'd0);
    end
  endtask

  task automatic simple_op(input logic [2:0] o, input logic [W-1:0] x);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    if (o == 3'd4) hi_m = x;
    if (o == 3'd5) lo_m = x;
    check("mt_busy", {63'd0, busy}, 64'd0);
    check("mt_done", {63'd0, done}, 64'd0);
    check("mt_hi", {32'd0, hi}, {32'd0, hi_m});
    check("mt_lo", {32'd0, lo}, {32'd0, lo_m});
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0);
    check("mult_hi_const", {32'd0, hi}, 64'hFFFF_FFFF);
    check("mult_lo_const", {32'd0, lo}, 64'hFFFF_FFFA);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("multu_hi_const", {32'd0, hi}, 64'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    check("div_lo_const", {32'd0, lo}, 64'hFFFF_FFFD);
    check("div_hi_const", {32'd0, hi}, 64'hFFFF_FFFF);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    check("divu_lo_const", {32'd0, lo}, 64'h7FFF_FFFC);
    run_op(3'd2, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    check("div0_lo_const", {32'd0, lo}, 64'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("ovf_lo_const", {32'd0, lo}, 64'h8000_0000);
    run_op(3'd3, 32'h8765_4321, 32'd0, 1'b1, 1'b0);

    simple_op(3'd4, 32'hA5A5_A5A5);
    simple_op(3'd5, 32'h5A5A_5A5A);
    simple_op(3'd6, 32'h1111_1111);
    simple_op(3'd7, 32'h2222_2222);

    run_op(3'd3, 32'd1000, 32'd7, 1'b1, 1'b1);
    run_op(3'd2, 32'hFFFF_FF00, 32'd13, 1'b0, 1'b0);
    run_op(3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
    run_op(3'd1, 32'd12345, 32'd678, 1'b1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 5))
        0: ry = '0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: ry = 32'($urandom_range(1, 20));
        default: ;
      endcase
      if (ro < 3'd4) run_op(ro, rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else simple_op(ro, rx);
    end

    simple_op(3'd4, 32'hDEAD_BEEF);
    simple_op(3'd5, 32'hCAFE_F00D);
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = $urandom; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_done", {63'd0, done}, 64'd0);
    check("rst_mid_hi", {32'd0, hi}, 64'd0);
    check("rst_mid_lo", {32'd0, lo}, 64'd0);
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd1, 32'd3, 32'd4, 1'b1, 1'b0);
    check("post_rst_lo_const", {32'd0, lo}, 64'd12);
    check("post_rst_hi_const", {32'd0, hi}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
